// File: rtl/dsi_video_timing_gen_if.sv
// Pixel-source bundle between the DSI timing generator and the transmitter.
// DSI_VTG_FRAME_CNT_EN adds the frame_cnt field.
interface dsi_video_timing_gen_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [23:0] pixel_data;
  logic        data_valid;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        line_start;
  logic        busy;
`ifdef DSI_VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (
    input  enable, pattern_sel, solid_rgb,
    output pixel_data, data_valid, hsync, vsync,
    output frame_start, line_start, busy, frame_cnt
  );

  modport slave (
    output enable, pattern_sel, solid_rgb,
    input  pixel_data, data_valid, hsync, vsync,
    input  frame_start, line_start, busy, frame_cnt
  );
`else
  modport master (
    input  enable, pattern_sel, solid_rgb,
    output pixel_data, data_valid, hsync, vsync,
    output frame_start, line_start, busy
  );

  modport slave (
    output enable, pattern_sel, solid_rgb,
    input  pixel_data, data_valid, hsync, vsync,
    input  frame_start, line_start, busy
  );
`endif
endinterface

// File: rtl/dsi_video_timing_gen.sv
// Raster timing + RGB888 test-pattern source for the DSI transmitter (pclk).
// Optional DSI_VTG_FRAME_CNT_EN: frame_cnt output, stamped into pattern 1.
module dsi_video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input logic                    pclk,
  input logic                    dsi_rst,
  dsi_video_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [31:0] HS  = 32'(H_SYNC);
  localparam logic [31:0] VS  = 32'(V_SYNC);
  localparam logic [31:0] HA0 = 32'(H_SYNC + H_BP);
  localparam logic [31:0] HA1 = 32'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [31:0] VA0 = 32'(V_SYNC + V_BP);
  localparam logic [31:0] VA1 = 32'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [31:0] BAR_W =
    (H_ACTIVE >= 8) ? 32'(H_ACTIVE / 8) : 32'd1;

  if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1)
  begin : g_bad_cfg
    $error("dsi_video_timing_gen: sync/active sizes must be >= 1");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [1:0]    r_sel;
  logic [23:0]   r_solid;
  logic [23:0]   r_pix;
  logic          r_dv;
  logic          r_hs;
  logic          r_vs;
  logic          r_fs;
  logic          r_ls;
  logic          r_busy;

  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] w_v_nxt;
  logic          w_run_nxt;
  logic [31:0]   w_hn;
  logic [31:0]   w_vn;
  logic [31:0]   w_x;
  logic [31:0]   w_bar;
  logic [2:0]    w_bi;
  logic [7:0]    w_y;
  logic          w_h_act;
  logic          w_v_act;
  logic          w_dv;
  logic          w_fs;
  logic [1:0]    w_sel;
  logic [23:0]   w_solid;
  logic [23:0]   w_bar_rgb;
  logic [23:0]   w_grad;
  logic [23:0]   w_pix;

  always_comb begin
    w_run_nxt = 1'b0;
    w_h_nxt   = '0;
    w_v_nxt   = '0;
    if (r_state == S_IDLE) begin
      w_run_nxt = vif.enable;
    end else if (r_h == H_LAST) begin
      if (r_v == V_LAST) begin
        w_run_nxt = vif.enable;
      end else begin
        w_run_nxt = 1'b1;
        w_v_nxt   = r_v + 1'b1;
      end
    end else begin
      w_run_nxt = 1'b1;
      w_h_nxt   = r_h + 1'b1;
      w_v_nxt   = r_v;
    end
  end

  // Outputs are decoded from the counter values of the cycle they appear in.
  assign w_hn    = 32'(w_h_nxt);
  assign w_vn    = 32'(w_v_nxt);
  assign w_h_act = (w_hn >= HA0) && (w_hn < HA1);
  assign w_v_act = (w_vn >= VA0) && (w_vn < VA1);
  assign w_dv    = w_run_nxt && w_h_act && w_v_act;
  assign w_fs    = w_run_nxt && (w_h_nxt == '0) && (w_v_nxt == '0);
  assign w_x     = w_hn - HA0;
  assign w_y     = 8'(w_vn - VA0);
  assign w_bar   = w_x / BAR_W;
  assign w_bi    = (w_bar > 32'd7) ? 3'd7 : w_bar[2:0];
  assign w_sel   = w_fs ? vif.pattern_sel : r_sel;
  assign w_solid = w_fs ? vif.solid_rgb : r_solid;

  always_comb begin
    w_bar_rgb = '0;
    unique case (w_bi)
      3'd0: w_bar_rgb = 24'hFFFFFF;
      3'd1: w_bar_rgb = 24'hFFFF00;
      3'd2: w_bar_rgb = 24'h00FFFF;
      3'd3: w_bar_rgb = 24'h00FF00;
      3'd4: w_bar_rgb = 24'hFF00FF;
      3'd5: w_bar_rgb = 24'hFF0000;
      3'd6: w_bar_rgb = 24'h0000FF;
      3'd7: w_bar_rgb = 24'h000000;
    endcase
  end

`ifdef DSI_VTG_FRAME_CNT_EN
  logic [15:0] r_fcnt;
  logic        r_fseen;

  // First frame after reset is frame 0; each later frame_start steps it.
  always_ff @(posedge pclk or negedge dsi_rst) begin
    if (!dsi_rst) begin
      r_fcnt  <= '0;
      r_fseen <= 1'b0;
    end else if (w_fs) begin
      r_fseen <= 1'b1;
      if (r_fseen) r_fcnt <= r_fcnt + 16'd1;
    end
  end

  assign vif.frame_cnt = r_fcnt;
  assign w_grad = {w_x[7:0], w_y, r_fcnt[7:0]};
`else
  assign w_grad = {w_x[7:0], w_x[7:0], w_y};
`endif

  always_comb begin
    w_pix = '0;
    unique case (w_sel)
      2'd0: w_pix = w_bar_rgb;
      2'd1: w_pix = w_grad;
      2'd2: w_pix = w_solid;
      2'd3: w_pix = (w_x[3] ^ w_y[3]) ? 24'hFFFFFF : 24'h000000;
    endcase
  end

  always_ff @(posedge pclk or negedge dsi_rst) begin
    if (!dsi_rst) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_sel   <= '0;
      r_solid <= '0;
      r_pix   <= '0;
      r_dv    <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_fs    <= 1'b0;
      r_ls    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_run_nxt ? S_RUN : S_IDLE;
      r_h     <= w_h_nxt;
      r_v     <= w_v_nxt;
      if (w_fs) begin
        r_sel   <= vif.pattern_sel;
        r_solid <= vif.solid_rgb;
      end
      r_pix  <= w_dv ? w_pix : '0;
      r_dv   <= w_dv;
      r_hs   <= w_run_nxt && (w_hn < HS);
      r_vs   <= w_run_nxt && (w_vn < VS);
      r_fs   <= w_fs;
      r_ls   <= w_dv && (w_hn == HA0);
      r_busy <= w_run_nxt;
    end
  end

  assign vif.pixel_data  = r_pix;
  assign vif.data_valid  = r_dv;
  assign vif.hsync       = r_hs;
  assign vif.vsync       = r_vs;
  assign vif.frame_start = r_fs;
  assign vif.line_start  = r_ls;
  assign vif.busy        = r_busy;

endmodule
